// File: rtl/vga_sprite_render_if.sv
// Video/control bundle between the VGA timing generator, the sprite register
// writer and the sprite pixel stage. The pixel stage is the slave: it consumes
// timing and control, and produces re-aligned syncs plus pixel colour.
interface vga_sprite_render_if #(
   parameter int COORD_W = 10
);
   // timing from the generator
   logic               hsync_in;
   logic               vsync_in;
   logic               de_in;
   logic               frame_in;
   logic [COORD_W-1:0] ux;
   logic [COORD_W-1:0] uy;

   // sprite control
   logic               sprite_en;
   logic [COORD_W-1:0] pos_x;
   logic [COORD_W-1:0] pos_y;
   logic               pos_wr;
   logic               bmp_wr;
   logic [2:0]         bmp_row;
   logic [15:0]        bmp_data;

   // re-aligned video out
   logic               hsync_out;
   logic               vsync_out;
   logic               de_out;
   logic [11:0]        rgb;
   logic               frame_out;

   modport master (
      output hsync_in, vsync_in, de_in, frame_in, ux, uy,
      output sprite_en, pos_x, pos_y, pos_wr, bmp_wr, bmp_row, bmp_data,
      input  hsync_out, vsync_out, de_out, rgb, frame_out
   );

   modport slave (
      input  hsync_in, vsync_in, de_in, frame_in, ux, uy,
      input  sprite_en, pos_x, pos_y, pos_wr, bmp_wr, bmp_row, bmp_data,
      output hsync_out, vsync_out, de_out, rgb, frame_out
   );
endinterface

// File: rtl/vga_sprite_render.sv
// Sprite pixel stage: draws one monochrome 16x8 sprite, scaled by
// 2^SCALE_SHIFT, over a flat background. Every output lags the timing inputs
// by exactly two clocks. Sprite position/enable are double-buffered and only
// change on the frame pulse, so a frame never shows two positions.
module vga_sprite_render #(
   parameter int          COORD_W     = 10,
   parameter int          SCALE_SHIFT = 1,     // 0..3
   parameter int          INIT_X      = 312,
   parameter int          INIT_Y      = 440,
   parameter logic [11:0] FG_RGB      = 12'h0F0,
   parameter logic [11:0] BG_RGB      = 12'h000
) (
   input  logic                     clk,
   input  logic                     rst,      // asynchronous, active-low
   vga_sprite_render_if.slave       vif
);

   // On-screen sprite footprint after scaling, in pixels.
   localparam logic [COORD_W:0] SPR_W = (COORD_W+1)'(16 << SCALE_SHIFT);
   localparam logic [COORD_W:0] SPR_H = (COORD_W+1)'(8 << SCALE_SHIFT);

   // ---------------------------------------------------------------------
   // Position / enable registers
   // ---------------------------------------------------------------------
   logic [COORD_W-1:0] pend_x_reg;
   logic [COORD_W-1:0] pend_y_reg;
   logic               pend_valid_reg;
   logic [COORD_W-1:0] active_x_reg;
   logic [COORD_W-1:0] active_y_reg;
   logic               active_en_reg;

   // Pending buffer and frame-pulse commit. A write in the commit cycle is
   // kept for the next frame; the commit uses what was pending beforehand.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_x_reg     <= '0;
         pend_y_reg     <= '0;
         pend_valid_reg <= 1'b0;
         active_x_reg   <= COORD_W'(INIT_X);
         active_y_reg   <= COORD_W'(INIT_Y);
         active_en_reg  <= 1'b1;
      end else begin
         if (vif.frame_in) begin
            active_en_reg <= vif.sprite_en;
            if (pend_valid_reg) begin
               active_x_reg <= pend_x_reg;
               active_y_reg <= pend_y_reg;
            end
         end
         if (vif.pos_wr) begin
            pend_x_reg     <= vif.pos_x;
            pend_y_reg     <= vif.pos_y;
            pend_valid_reg <= 1'b1;
         end else if (vif.frame_in && pend_valid_reg) begin
            pend_valid_reg <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Bitmap: 8 rows of 16 bits, bit 15 is the leftmost pixel. Writes are
   // not buffered; a mid-frame update may show on the current frame.
   // ---------------------------------------------------------------------
   logic [15:0] bmp_reg [8];

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_row
         // One register row per bitmap line, loaded when its index is written.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               bmp_reg[gi] <= '0;
            end else if (vif.bmp_wr && (vif.bmp_row == 3'(gi))) begin
               bmp_reg[gi] <= vif.bmp_data;
            end
         end
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Stage 1: sprite-relative coordinates and hit test
   // ---------------------------------------------------------------------
   // One extra bit makes the subtraction signed: the MSB flags ux < active_x,
   // which is simply "left of / above the sprite" (no wrap-around hit).
   logic [COORD_W:0] dx;
   logic [COORD_W:0] dy;
   logic             in_x;
   logic             in_y;
   logic             hit_next;
   logic [3:0]       col_next;
   logic [2:0]       row_next;

   assign dx       = {1'b0, vif.ux} - {1'b0, active_x_reg};
   assign dy       = {1'b0, vif.uy} - {1'b0, active_y_reg};
   assign in_x     = !dx[COORD_W] && (dx < SPR_W);
   assign in_y     = !dy[COORD_W] && (dy < SPR_H);
   assign hit_next = vif.de_in && active_en_reg && in_x && in_y;
   assign col_next = 4'(dx >> SCALE_SHIFT);
   assign row_next = 3'(dy >> SCALE_SHIFT);

   logic       hsync1_reg;
   logic       vsync1_reg;
   logic       de1_reg;
   logic       frame1_reg;
   logic       hit1_reg;
   logic [3:0] col1_reg;
   logic [2:0] row1_reg;

   // First pipeline stage: hit test result with timing carried alongside.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hsync1_reg <= 1'b1;
         vsync1_reg <= 1'b1;
         de1_reg    <= 1'b0;
         frame1_reg <= 1'b0;
         hit1_reg   <= 1'b0;
         col1_reg   <= '0;
         row1_reg   <= '0;
      end else begin
         hsync1_reg <= vif.hsync_in;
         vsync1_reg <= vif.vsync_in;
         de1_reg    <= vif.de_in;
         frame1_reg <= vif.frame_in;
         hit1_reg   <= hit_next;
         col1_reg   <= col_next;
         row1_reg   <= row_next;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: bitmap lookup and colour selection
   // ---------------------------------------------------------------------
   logic        pix;
   logic [11:0] rgb_next;

   assign pix      = hit1_reg && bmp_reg[row1_reg][4'd15 - col1_reg];
   // Blanking is forced black regardless of the background colour.
   assign rgb_next = !de1_reg ? 12'h000 : (pix ? FG_RGB : BG_RGB);

   logic        hsync2_reg;
   logic        vsync2_reg;
   logic        de2_reg;
   logic        frame2_reg;
   logic [11:0] rgb2_reg;

   // Second pipeline stage: final colour, syncs aligned to the same clock.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hsync2_reg <= 1'b1;
         vsync2_reg <= 1'b1;
         de2_reg    <= 1'b0;
         frame2_reg <= 1'b0;
         rgb2_reg   <= '0;
      end else begin
         hsync2_reg <= hsync1_reg;
         vsync2_reg <= vsync1_reg;
         de2_reg    <= de1_reg;
         frame2_reg <= frame1_reg;
         rgb2_reg   <= rgb_next;
      end
   end

   assign vif.hsync_out = hsync2_reg;
   assign vif.vsync_out = vsync2_reg;
   assign vif.de_out    = de2_reg;
   assign vif.frame_out = frame2_reg;
   assign vif.rgb       = rgb2_reg;

endmodule

// File: tb/tb_vga_sprite_render.sv
// Directed bench for vga_sprite_render: two instances (scale 1x and 2x) share
// the same stimulus; each probe drives one pixel and reads it back 2 clocks on.
module tb_vga_sprite_render;

   localparam logic [11:0] FG = 12'h0F0;
   localparam logic [11:0] BG = 12'h000;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int checks   = 0;
   int failures = 0;

   vga_sprite_render_if #(.COORD_W(10)) vif0 ();
   vga_sprite_render_if #(.COORD_W(10)) vif1 ();

   // second instance mirrors the stimulus of the first
   assign vif1.hsync_in  = vif0.hsync_in;
   assign vif1.vsync_in  = vif0.vsync_in;
   assign vif1.de_in     = vif0.de_in;
   assign vif1.frame_in  = vif0.frame_in;
   assign vif1.ux        = vif0.ux;
   assign vif1.uy        = vif0.uy;
   assign vif1.sprite_en = vif0.sprite_en;
   assign vif1.pos_x     = vif0.pos_x;
   assign vif1.pos_y     = vif0.pos_y;
   assign vif1.pos_wr    = vif0.pos_wr;
   assign vif1.bmp_wr    = vif0.bmp_wr;
   assign vif1.bmp_row   = vif0.bmp_row;
   assign vif1.bmp_data  = vif0.bmp_data;

   vga_sprite_render #(.COORD_W(10), .SCALE_SHIFT(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .vif (vif0.slave)
   );

   vga_sprite_render #(.COORD_W(10), .SCALE_SHIFT(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .vif (vif1.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      vif0.hsync_in = 1'b1;
      vif0.vsync_in = 1'b1;
      vif0.de_in    = 1'b0;
      vif0.frame_in = 1'b0;
      vif0.ux       = '0;
      vif0.uy       = '0;
      vif0.pos_wr   = 1'b0;
      vif0.bmp_wr   = 1'b0;
   endtask

   // drive one pixel, blank the next cycle, sample both DUTs 2 clocks later
   task automatic probe(input int x, input int y, input logic de,
                        output logic [11:0] r0, output logic [11:0] r1, output logic d1);
      @(negedge clk);
      vif0.ux = 10'(x); vif0.uy = 10'(y); vif0.de_in = de;
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      r0 = vif0.rgb; r1 = vif1.rgb; d1 = vif1.de_out;
      $display("probe x=%0d y=%0d de=%0b -> rgb0=%03h rgb1=%03h de_out=%0b", x, y, de, r0, r1, d1);
   endtask

   task automatic write_row(input logic [2:0] row, input logic [15:0] data);
      @(negedge clk);
      vif0.bmp_wr = 1'b1; vif0.bmp_row = row; vif0.bmp_data = data;
      @(negedge clk);
      vif0.bmp_wr = 1'b0;
      $display("bmp row=%0d data=%04h", row, data);
   endtask

   task automatic write_pos(input int x, input int y);
      @(negedge clk);
      vif0.pos_wr = 1'b1; vif0.pos_x = 10'(x); vif0.pos_y = 10'(y);
      @(negedge clk);
      vif0.pos_wr = 1'b0;
      $display("pos_wr x=%0d y=%0d", x, y);
   endtask

   task automatic frame_pulse(input logic en);
      @(negedge clk);
      vif0.frame_in = 1'b1; vif0.sprite_en = en;
      @(negedge clk);
      vif0.frame_in = 1'b0;
      $display("frame sprite_en=%0b", en);
   endtask

   logic [11:0] r0, r1;
   logic        d1;

   initial begin
      idle_inputs();
      vif0.sprite_en = 1'b1;
      vif0.pos_x     = '0;
      vif0.pos_y     = '0;
      vif0.bmp_row   = '0;
      vif0.bmp_data  = '0;

      // reset state
      #12;
      check("rst_hsync", 32'(vif1.hsync_out), 32'd1);
      check("rst_vsync", 32'(vif1.vsync_out), 32'd1);
      check("rst_de",    32'(vif1.de_out),    32'd0);
      check("rst_frame", 32'(vif1.frame_out), 32'd0);
      check("rst_rgb",   32'(vif1.rgb),       32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("idle_hsync", 32'(vif1.hsync_out), 32'd1);
      check("idle_rgb",   32'(vif1.rgb),       32'd0);

      // sync/frame latency: 2 clocks
      @(negedge clk);
      vif0.hsync_in = 1'b0; vif0.vsync_in = 1'b0; vif0.frame_in = 1'b1;
      @(negedge clk);
      idle_inputs();
      check("hsync_lat1", 32'(vif1.hsync_out), 32'd1);
      @(negedge clk);
      check("hsync_lat2", 32'(vif1.hsync_out), 32'd0);
      check("vsync_lat2", 32'(vif1.vsync_out), 32'd0);
      check("frame_lat2", 32'(vif1.frame_out), 32'd1);
      @(negedge clk);
      check("hsync_lat3", 32'(vif1.hsync_out), 32'd1);
      check("frame_lat3", 32'(vif1.frame_out), 32'd0);

      // 1x scale, row0 = 8001 at default position
      write_row(3'd0, 16'h8001);
      write_row(3'd3, 16'h4000);
      probe(312, 440, 1'b1, r0, r1, d1); check("s0_312", 32'(r0), 32'(FG)); check("s0_de", 32'(d1), 32'd1);
      probe(327, 440, 1'b1, r0, r1, d1); check("s0_327", 32'(r0), 32'(FG));
      probe(313, 440, 1'b1, r0, r1, d1); check("s0_313", 32'(r0), 32'(BG));
      probe(328, 440, 1'b1, r0, r1, d1); check("s0_328", 32'(r0), 32'(BG));
      probe(313, 443, 1'b1, r0, r1, d1); check("s0_row3", 32'(r0), 32'(FG));
      probe(312, 440, 1'b0, r0, r1, d1); check("s0_blank", 32'(r0), 32'd0);

      // 2x scale, row0 = 8000
      write_row(3'd0, 16'h8000);
      probe(312, 440, 1'b1, r0, r1, d1); check("s1_312_440", 32'(r1), 32'(FG));
      probe(313, 440, 1'b1, r0, r1, d1); check("s1_313_440", 32'(r1), 32'(FG));
      probe(312, 441, 1'b1, r0, r1, d1); check("s1_312_441", 32'(r1), 32'(FG));
      probe(313, 441, 1'b1, r0, r1, d1); check("s1_313_441", 32'(r1), 32'(FG));
      probe(314, 440, 1'b1, r0, r1, d1); check("s1_314", 32'(r1), 32'(BG));
      probe(312, 442, 1'b1, r0, r1, d1); check("s1_312_442", 32'(r1), 32'(BG));

      // position is buffered until the frame pulse
      write_pos(100, 200);
      probe(312, 440, 1'b1, r0, r1, d1); check("pend_old_pos", 32'(r1), 32'(FG));
      probe(100, 200, 1'b1, r0, r1, d1); check("pend_new_pos", 32'(r1), 32'(BG));
      check("pend_valid1", 32'(dut1.pend_valid_reg), 32'd1);
      frame_pulse(1'b1);
      probe(100, 200, 1'b1, r0, r1, d1); check("commit_new", 32'(r1), 32'(FG));
      probe(312, 440, 1'b1, r0, r1, d1); check("commit_old", 32'(r1), 32'(BG));
      check("pend_valid0", 32'(dut1.pend_valid_reg), 32'd0);

      // write in the commit cycle lands for the next frame
      write_pos(400, 300);
      frame_pulse(1'b1);
      write_pos(100, 200);
      @(negedge clk);
      vif0.pos_wr = 1'b1; vif0.pos_x = 10'd50; vif0.pos_y = 10'd60; vif0.frame_in = 1'b1;
      @(negedge clk);
      vif0.pos_wr = 1'b0; vif0.frame_in = 1'b0;
      $display("pos_wr x=50 y=60 with frame");
      probe(100, 200, 1'b1, r0, r1, d1); check("same_cyc_commit", 32'(r1), 32'(FG));
      probe(50, 60, 1'b1, r0, r1, d1);   check("same_cyc_later", 32'(r1), 32'(BG));
      probe(400, 300, 1'b1, r0, r1, d1); check("same_cyc_prev", 32'(r1), 32'(BG));
      check("same_cyc_pend", 32'(dut1.pend_valid_reg), 32'd1);
      frame_pulse(1'b1);
      probe(50, 60, 1'b1, r0, r1, d1);   check("next_commit", 32'(r1), 32'(FG));
      probe(100, 200, 1'b1, r0, r1, d1); check("next_old", 32'(r1), 32'(BG));
      check("next_pend", 32'(dut1.pend_valid_reg), 32'd0);

      // right-edge clipping, no wrap-around
      write_row(3'd0, 16'hFFFF);
      write_pos(630, 60);
      frame_pulse(1'b1);
      probe(630, 60, 1'b1, r0, r1, d1); check("edge_630", 32'(r1), 32'(FG));
      probe(635, 60, 1'b1, r0, r1, d1); check("edge_635", 32'(r1), 32'(FG));
      probe(639, 60, 1'b1, r0, r1, d1); check("edge_639", 32'(r1), 32'(FG));
      probe(640, 60, 1'b0, r0, r1, d1); check("edge_640_rgb", 32'(r1), 32'd0); check("edge_640_de", 32'(d1), 32'd0);
      probe(0, 61, 1'b1, r0, r1, d1);   check("wrap_0", 32'(r1), 32'(BG)); check("wrap_0_de", 32'(d1), 32'd1);
      probe(5, 61, 1'b1, r0, r1, d1);   check("wrap_5", 32'(r1), 32'(BG));

      // sprite disable takes effect on the frame pulse
      frame_pulse(1'b0);
      probe(630, 60, 1'b1, r0, r1, d1); check("dis_bg", 32'(r1), 32'(BG)); check("dis_de", 32'(d1), 32'd1);
      frame_pulse(1'b1);
      probe(630, 60, 1'b1, r0, r1, d1); check("reen_fg", 32'(r1), 32'(FG));

      // asynchronous reset mid-frame
      write_pos(10, 10);
      @(negedge clk);
      vif0.ux = 10'd630; vif0.uy = 10'd60; vif0.de_in = 1'b1; vif0.hsync_in = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_rgb",   32'(vif1.rgb),       32'(FG));
      check("pre_rst_hsync", 32'(vif1.hsync_out), 32'd0);
      #2 rst = 1'b0;
      #1;
      check("arst_hsync", 32'(vif1.hsync_out), 32'd1);
      check("arst_vsync", 32'(vif1.vsync_out), 32'd1);
      check("arst_de",    32'(vif1.de_out),    32'd0);
      check("arst_rgb",   32'(vif1.rgb),       32'd0);
      check("arst_frame", 32'(vif1.frame_out), 32'd0);
      $display("async reset asserted mid-frame");
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
      check("arst_pend", 32'(dut1.pend_valid_reg), 32'd0);
      probe(630, 60, 1'b1, r0, r1, d1); check("arst_bmp_clear", 32'(r1), 32'(BG));
      write_row(3'd0, 16'h8000);
      probe(312, 440, 1'b1, r0, r1, d1); check("arst_init_pos", 32'(r1), 32'(FG));
      probe(313, 441, 1'b1, r0, r1, d1); check("arst_init_pos2", 32'(r1), 32'(FG));
      probe(630, 60, 1'b1, r0, r1, d1);  check("arst_old_pos", 32'(r1), 32'(BG));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
